// File: rtl/wisc_pkg.sv
// Shared constants and fetch state encoding for the fetch stage.
package wisc_pkg;
    localparam logic [15:0] RESET_PC    = 16'h0000;
    localparam logic [15:0] NOP_INSTR   = 16'h0800;
    localparam logic [4:0]  HALT_OPCODE = 5'b00000;

    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;
endpackage

// File: rtl/dff.sv
// Generic register with synchronous active-high reset and load enable.
module dff #(
    parameter int          W       = 16,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst)       r_q <= RST_VAL;
        else if (i_en) r_q <= i_d;
    end

    assign o_q = r_q;
endmodule

// File: rtl/fetch_hold_buf.sv
// Holds a fetched instruction while decode stalls; clear wins over load.
module fetch_hold_buf
    import wisc_pkg::*;
#(
    parameter logic [15:0] NOP = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [15:0] i_data,
    output logic [15:0] o_data
);
    logic [15:0] w_d;

    assign w_d = i_clear ? NOP : i_data;

    dff #(.W(16), .RST_VAL(NOP)) u_hold_q (
        .clk  (clk),
        .rst  (rst),
        .i_en (i_load | i_clear),
        .i_d  (w_d),
        .o_q  (o_data)
    );
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives the imem request/done handshake,
// buffers a word across decode stalls, and honours redirects and HALT.
module fetch_unit
    import wisc_pkg::*;
#(
    parameter logic [15:0] RESET_PC_P    = RESET_PC,
    parameter logic [15:0] NOP_INSTR_P   = NOP_INSTR,
    parameter logic [4:0]  HALT_OPCODE_P = HALT_OPCODE
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    input  logic        stall_in,
    input  logic        redirect_en,
    input  logic [15:0] redirect_pc,
    output logic        if_valid,
    output logic [15:0] instruction_out,
    output logic [15:0] PC_NO_PLUS_TWO_OUT,
    output logic [15:0] PC_next_out,
    output logic        halt_out,
    output logic [1:0]  dbg_state
);
    fetch_state_e r_state;
    fetch_state_e w_state_d;
    logic [15:0]  w_pc;
    logic [15:0]  w_pc_d;
    logic [15:0]  w_pc_plus2;
    logic [15:0]  w_hold;
    logic         w_hold_load;
    logic         w_hold_clr;
    logic         w_rd_is_halt;
    logic         w_hold_is_halt;

    dff #(.W(16), .RST_VAL(RESET_PC_P)) u_pc_q (
        .clk  (clk),
        .rst  (rst),
        .i_en (1'b1),
        .i_d  (w_pc_d),
        .o_q  (w_pc)
    );

    fetch_hold_buf #(.NOP(NOP_INSTR_P)) u_hold (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_hold_load),
        .i_clear (w_hold_clr),
        .i_data  (imem_rdata),
        .o_data  (w_hold)
    );

    assign w_pc_plus2     = w_pc + 16'd2;
    assign w_rd_is_halt   = (imem_rdata[15:11] == HALT_OPCODE_P);
    assign w_hold_is_halt = (w_hold[15:11] == HALT_OPCODE_P);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_REQ;
        else     r_state <= w_state_d;
    end

    // Outputs are combinational so a same-cycle imem_done can be passed straight through.
    always_comb begin
        imem_rd         = 1'b0;
        if_valid        = 1'b0;
        instruction_out = NOP_INSTR_P;
        halt_out        = 1'b0;
        w_state_d       = r_state;
        w_pc_d          = w_pc;
        w_hold_load     = 1'b0;
        w_hold_clr      = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_REQ: begin
                    imem_rd = 1'b1;
                    if (imem_done) begin
                        if_valid        = 1'b1;
                        instruction_out = imem_rdata;
                        if (stall_in) begin
                            w_hold_load = 1'b1;
                            w_state_d   = ST_HOLD;
                        end else if (w_rd_is_halt) begin
                            w_state_d = ST_HALTED;
                        end else begin
                            w_pc_d = w_pc_plus2;
                        end
                    end
                end
                ST_HOLD: begin
                    if_valid        = 1'b1;
                    instruction_out = w_hold;
                    if (!stall_in) begin
                        if (w_hold_is_halt) begin
                            w_state_d = ST_HALTED;
                        end else begin
                            w_pc_d    = w_pc_plus2;
                            w_state_d = ST_REQ;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (imem_done) w_state_d = ST_REQ;
                end
                default: begin
                    halt_out = 1'b1;
                end
            endcase
            // A redirect overrides everything; an in-flight request must be drained first.
            if (redirect_en) begin
                if_valid        = 1'b0;
                instruction_out = NOP_INSTR_P;
                w_pc_d          = redirect_pc & 16'hFFFE;
                w_hold_load     = 1'b0;
                w_hold_clr      = 1'b1;
                if ((r_state == ST_REQ || r_state == ST_DRAIN) && !imem_done)
                    w_state_d = ST_DRAIN;
                else
                    w_state_d = ST_REQ;
            end
        end
    end

    assign imem_addr          = w_pc;
    assign PC_NO_PLUS_TWO_OUT = w_pc;
    assign PC_next_out        = w_pc_plus2;
    assign dbg_state          = r_state;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: inputs change 1ns after posedge, outputs checked 2ns later.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_done;
    logic        stall_in;
    logic        redirect_en;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic [15:0] instruction_out;
    logic [15:0] pc_out;
    logic [15:0] pc_next;
    logic        halt_out;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk                (clk),
        .rst                (rst),
        .imem_rd            (imem_rd),
        .imem_addr          (imem_addr),
        .imem_rdata         (imem_rdata),
        .imem_done          (imem_done),
        .stall_in           (stall_in),
        .redirect_en        (redirect_en),
        .redirect_pc        (redirect_pc),
        .if_valid           (if_valid),
        .instruction_out    (instruction_out),
        .PC_NO_PLUS_TWO_OUT (pc_out),
        .PC_next_out        (pc_next),
        .halt_out           (halt_out),
        .dbg_state          (dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Redirect with imem_done high so the unit goes straight to REQ at the target.
    task automatic do_redirect(input logic [15:0] tgt);
        redirect_en = 1'b1; redirect_pc = tgt; imem_done = 1'b1; stall_in = 1'b0;
        imem_rdata = 16'h8888;
        settle();
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL redir_valid got=%b exp=0", if_valid); end
        total++; if (instruction_out !== 16'h0800) begin bad++; $display("FAIL redir_nop got=%h exp=0800", instruction_out); end
        tick();
        redirect_en = 1'b0; imem_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_done = 1'b0; imem_rdata = 16'h0; stall_in = 1'b0;
        redirect_en = 1'b0; redirect_pc = 16'h0;
        tick(); settle();
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", if_valid); end
        total++; if (instruction_out !== 16'h0800) begin bad++; $display("FAIL rst_instr got=%h exp=0800", instruction_out); end
        total++; if (imem_rd !== 1'b0) begin bad++; $display("FAIL rst_rd got=%b exp=0", imem_rd); end
        total++; if (halt_out !== 1'b0) begin bad++; $display("FAIL rst_halt got=%b exp=0", halt_out); end
        total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL rst_addr got=%h exp=0000", imem_addr); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [15:0] exp_addr [3];
        exp_addr[0] = 16'h0000; exp_addr[1] = 16'h0002; exp_addr[2] = 16'h0004;
        for (int i = 0; i < 3; i++) begin
            imem_done = 1'b1; imem_rdata = 16'hA000 | exp_addr[i];
            settle();
            total++; if (imem_addr !== exp_addr[i]) begin bad++; $display("FAIL stream_addr%0d got=%h exp=%h", i, imem_addr, exp_addr[i]); end
            total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL stream_valid%0d got=%b exp=1", i, if_valid); end
            total++; if (instruction_out !== (16'hA000 | exp_addr[i])) begin bad++; $display("FAIL stream_instr%0d got=%h exp=%h", i, instruction_out, 16'hA000 | exp_addr[i]); end
            total++; if (pc_next !== exp_addr[i] + 16'd2) begin bad++; $display("FAIL stream_next%0d got=%h exp=%h", i, pc_next, exp_addr[i] + 16'd2); end
            tick();
        end
        imem_done = 1'b0;
    endtask

    task automatic test_delayed_done();
        do_redirect(16'h0010);
        for (int i = 0; i < 3; i++) begin
            imem_done = 1'b0; imem_rdata = 16'hDEAD;
            settle();
            total++; if (imem_addr !== 16'h0010 || imem_rd !== 1'b1) begin bad++; $display("FAIL wait_req%0d addr=%h rd=%b exp=0010/1", i, imem_addr, imem_rd); end
            total++; if (if_valid !== 1'b0 || instruction_out !== 16'h0800) begin bad++; $display("FAIL wait_nop%0d valid=%b instr=%h exp=0/0800", i, if_valid, instruction_out); end
            tick();
        end
        imem_done = 1'b1; imem_rdata = 16'h5678;
        settle();
        total++; if (if_valid !== 1'b1 || instruction_out !== 16'h5678) begin bad++; $display("FAIL late_instr valid=%b instr=%h exp=1/5678", if_valid, instruction_out); end
        total++; if (pc_out !== 16'h0010) begin bad++; $display("FAIL late_pc got=%h exp=0010", pc_out); end
        tick();
        imem_done = 1'b0;
        settle();
        total++; if (imem_addr !== 16'h0012) begin bad++; $display("FAIL late_next got=%h exp=0012", imem_addr); end
    endtask

    task automatic test_stall();
        do_redirect(16'h0020);
        imem_done = 1'b1; imem_rdata = 16'h1234; stall_in = 1'b1;
        settle();
        total++; if (if_valid !== 1'b1 || instruction_out !== 16'h1234) begin bad++; $display("FAIL stall_first valid=%b instr=%h exp=1/1234", if_valid, instruction_out); end
        tick();
        imem_done = 1'b0; imem_rdata = 16'hBEEF;
        for (int i = 0; i < 2; i++) begin
            settle();
            total++; if (instruction_out !== 16'h1234 || if_valid !== 1'b1) begin bad++; $display("FAIL hold_instr%0d instr=%h valid=%b exp=1234/1", i, instruction_out, if_valid); end
            total++; if (imem_rd !== 1'b0) begin bad++; $display("FAIL hold_rd%0d got=%b exp=0", i, imem_rd); end
            total++; if (pc_out !== 16'h0020) begin bad++; $display("FAIL hold_pc%0d got=%h exp=0020", i, pc_out); end
            if (i == 0) tick();
            else stall_in = 1'b0;
        end
        settle();
        total++; if (instruction_out !== 16'h1234) begin bad++; $display("FAIL release_instr got=%h exp=1234", instruction_out); end
        tick();
        settle();
        total++; if (imem_addr !== 16'h0022 || imem_rd !== 1'b1) begin bad++; $display("FAIL release_next addr=%h rd=%b exp=0022/1", imem_addr, imem_rd); end
    endtask

    task automatic test_redirect_drain();
        imem_done = 1'b0; redirect_en = 1'b1; redirect_pc = 16'h0101;
        settle();
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL drain_redir_valid got=%b exp=0", if_valid); end
        tick();
        redirect_en = 1'b0;
        settle();
        total++; if (imem_rd !== 1'b0 || if_valid !== 1'b0) begin bad++; $display("FAIL drain_idle rd=%b valid=%b exp=0/0", imem_rd, if_valid); end
        tick();
        imem_done = 1'b1; imem_rdata = 16'h4444;
        settle();
        total++; if (if_valid !== 1'b0 || instruction_out !== 16'h0800) begin bad++; $display("FAIL drain_drop valid=%b instr=%h exp=0/0800", if_valid, instruction_out); end
        tick();
        imem_done = 1'b0;
        settle();
        total++; if (imem_addr !== 16'h0100 || imem_rd !== 1'b1) begin bad++; $display("FAIL drain_resume addr=%h rd=%b exp=0100/1", imem_addr, imem_rd); end
    endtask

    task automatic test_halt();
        do_redirect(16'h0040);
        imem_done = 1'b1; imem_rdata = 16'h0000;
        settle();
        total++; if (if_valid !== 1'b1 || instruction_out !== 16'h0000) begin bad++; $display("FAIL halt_word valid=%b instr=%h exp=1/0000", if_valid, instruction_out); end
        tick();
        imem_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            total++; if (halt_out !== 1'b1 || imem_rd !== 1'b0 || if_valid !== 1'b0) begin bad++; $display("FAIL halted%0d halt=%b rd=%b valid=%b exp=1/0/0", i, halt_out, imem_rd, if_valid); end
            total++; if (pc_out !== 16'h0040) begin bad++; $display("FAIL halted_pc%0d got=%h exp=0040", i, pc_out); end
            tick();
        end
        redirect_en = 1'b1; redirect_pc = 16'h0080;
        tick();
        redirect_en = 1'b0;
        settle();
        total++; if (imem_addr !== 16'h0080 || imem_rd !== 1'b1 || halt_out !== 1'b0) begin bad++; $display("FAIL halt_resume addr=%h rd=%b halt=%b exp=0080/1/0", imem_addr, imem_rd, halt_out); end
    endtask

    task automatic test_wrap_and_rst_hold();
        do_redirect(16'hFFFE);
        imem_done = 1'b1; imem_rdata = 16'h8000;
        settle();
        total++; if (pc_next !== 16'h0000) begin bad++; $display("FAIL wrap_next got=%h exp=0000", pc_next); end
        tick();
        settle();
        total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL wrap_addr got=%h exp=0000", imem_addr); end
        do_redirect(16'h0200);
        imem_done = 1'b1; imem_rdata = 16'h9999; stall_in = 1'b1;
        tick();
        imem_done = 1'b0;
        settle();
        total++; if (instruction_out !== 16'h9999 || imem_rd !== 1'b0) begin bad++; $display("FAIL pre_rst_hold instr=%h rd=%b exp=9999/0", instruction_out, imem_rd); end
        rst = 1'b1;
        tick();
        rst = 1'b0; stall_in = 1'b0;
        settle();
        total++; if (if_valid !== 1'b0 || instruction_out !== 16'h0800) begin bad++; $display("FAIL post_rst_valid valid=%b instr=%h exp=0/0800", if_valid, instruction_out); end
        total++; if (imem_addr !== 16'h0000 || imem_rd !== 1'b1) begin bad++; $display("FAIL post_rst_req addr=%h rd=%b exp=0000/1", imem_addr, imem_rd); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_delayed_done();
        test_stall();
        test_redirect_drain();
        test_halt();
        test_wrap_and_rst_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
